// File: rtl/ram_pkg.sv
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared types and constants for the ram_sp_hs block.
//                Holds the FSM state encoding, the read-latency ceiling
//                and the byte-count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

   // Controller states: INIT clears the array, RUN serves requests.
   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Deepest read pipeline supported.
   localparam int RD_LAT_MAX = 4;

   // Number of byte lanes in a data word.
   function automatic int byte_count(input int dw);
      return dw / 8;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_sp_hs_if.sv
// ============================================================================
//  Module      : ram_sp_hs_if
//  Description : Request/response bus between a requester (master) and the
//                ram_sp_hs storage block (slave).
//  Signals     : req_valid/req_ready handshake, req_we, req_addr, req_wdata,
//                req_be (byte enables), rsp_valid, rsp_rdata, rsp_err,
//                init_done; par_inj only when PARITY_EN is defined.
//  Macro       : PARITY_EN adds the par_inj request signal.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_sp_hs_if #(
   parameter int ADDRWIDTH = 4,
   parameter int DATAWIDTH = 8
) ();

   logic                     req_valid;
   logic                     req_ready;
   logic                     req_we;
   logic [ADDRWIDTH-1:0]     req_addr;
   logic [DATAWIDTH-1:0]     req_wdata;
   logic [DATAWIDTH/8-1:0]   req_be;
   logic                     rsp_valid;
   logic [DATAWIDTH-1:0]     rsp_rdata;
   logic                     rsp_err;
   logic                     init_done;
`ifdef PARITY_EN
   logic                     par_inj;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, par_inj,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, par_inj,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );
`else
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );
`endif

endinterface

`default_nettype wire

// File: rtl/ram_rd_pipe.sv
// ============================================================================
//  Module      : ram_rd_pipe
//  Description : Read-response delay line of DEPTH stages carrying
//                {valid, data, err}. Stage 0 is loaded from the array read.
//  Ports       : clk, rst_n (sync, active-low, invalidates every stage),
//                in_valid/in_data/in_err (array read), out_valid/out_data/
//                out_err (last stage).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_rd_pipe #(
   parameter int DATAWIDTH = 8,
   parameter int DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [DATAWIDTH-1:0] in_data,
   input  logic                 in_err,
   output logic                 out_valid,
   output logic [DATAWIDTH-1:0] out_data,
   output logic                 out_err
);

   logic                 r_vld  [DEPTH];
   logic [DATAWIDTH-1:0] r_data [DEPTH];
   logic                 r_err  [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_vld[k]  <= 1'b0;
            r_data[k] <= '0;
            r_err[k]  <= 1'b0;
         end
      end else begin
         // Empty slots carry zero data so the output is clean when idle.
         r_vld[0]  <= in_valid;
         r_data[0] <= in_valid ? in_data : '0;
         r_err[0]  <= in_valid & in_err;
         for (int k = 1; k < DEPTH; k++) begin
            r_vld[k]  <= r_vld[k-1];
            r_data[k] <= r_data[k-1];
            r_err[k]  <= r_err[k-1];
         end
      end
   end

   assign out_valid = r_vld[DEPTH-1];
   assign out_data  = r_data[DEPTH-1];
   assign out_err   = r_err[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/ram_sp_hs.sv
// ============================================================================
//  Module      : ram_sp_hs
//  Description : Single-port synchronous RAM with valid/ready requests,
//                per-byte write enables and a pipelined read path. Clears
//                the whole array after reset, then accepts one request per
//                cycle.
//  Ports       : clk, rst_n (sync, active-low), bus (ram_sp_hs_if.slave).
//  Parameters  : ADDRWIDTH, DATAWIDTH (multiple of 8), SIZE (<= 2**ADDRWIDTH),
//                RD_LAT (1..RD_LAT_MAX, request cycle to rsp_valid cycle).
//  Macro       : PARITY_EN - even parity bit per byte, par_inj on the bus
//                inverts stored parity, parity mismatch raises rsp_err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sp_hs
   import ram_pkg::*;
#(
   parameter int ADDRWIDTH = 4,
   parameter int DATAWIDTH = 8,
   parameter int SIZE      = 16,
   parameter int RD_LAT    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   ram_sp_hs_if.slave  bus
);

   localparam int                   c_NB   = byte_count(DATAWIDTH);
   localparam int                   c_LAT  = (RD_LAT < 1) ? 1 :
                                             (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
   localparam logic [ADDRWIDTH:0]   c_SIZE = (ADDRWIDTH+1)'(SIZE);
   localparam logic [ADDRWIDTH-1:0] c_LAST = ADDRWIDTH'(SIZE - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDRWIDTH-1:0]  r_ptr;
   logic [ADDRWIDTH-1:0]  w_ptr_nxt;

   logic [DATAWIDTH-1:0]  r_mem [SIZE];

   logic                  w_accept;
   logic                  w_in_range;
   logic                  w_wr;
   logic                  w_rd;
   logic [DATAWIDTH-1:0]  w_rd_data;
   logic                  w_rd_err;

   logic                  w_pipe_vld;
   logic [DATAWIDTH-1:0]  w_pipe_data;
   logic                  w_pipe_err;

   // ---------------- controller ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      bus.req_ready = 1'b0;
      bus.init_done = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_ptr_nxt = r_ptr + 1'b1;
            if (r_ptr == c_LAST) begin
               w_state_nxt = ST_RUN;
               w_ptr_nxt   = '0;
            end
         end
         ST_RUN: begin
            bus.req_ready = 1'b1;
            bus.init_done = 1'b1;
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // ---------------- request decode ----------------
   assign w_accept   = bus.req_valid & bus.req_ready;
   assign w_in_range = ({1'b0, bus.req_addr} < c_SIZE);
   assign w_wr       = w_accept & bus.req_we & w_in_range;
   assign w_rd       = w_accept & ~bus.req_we;

   // ---------------- storage ----------------
`ifdef PARITY_EN
   logic [c_NB-1:0] r_par [SIZE];
`endif

   // Gated by rst_n so a request seen on the reset edge cannot land.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (r_state == ST_INIT) begin
            r_mem[r_ptr] <= '0;
`ifdef PARITY_EN
            r_par[r_ptr] <= '0;
`endif
         end else if (w_wr) begin
            for (int i = 0; i < c_NB; i++) begin
               if (bus.req_be[i]) begin
                  r_mem[bus.req_addr][i*8 +: 8] <= bus.req_wdata[i*8 +: 8];
`ifdef PARITY_EN
                  r_par[bus.req_addr][i] <= (^bus.req_wdata[i*8 +: 8]) ^ bus.par_inj;
`endif
               end
            end
         end
      end
   end

   // Out-of-range reads return zero data flagged as an error.
   always_comb begin
      w_rd_data = '0;
      w_rd_err  = 1'b1;
      if (w_in_range) begin
         w_rd_data = r_mem[bus.req_addr];
         w_rd_err  = 1'b0;
`ifdef PARITY_EN
         for (int i = 0; i < c_NB; i++) begin
            if ((^r_mem[bus.req_addr][i*8 +: 8]) != r_par[bus.req_addr][i]) begin
               w_rd_err = 1'b1;
            end
         end
`endif
      end
   end

   // ---------------- read pipeline ----------------
   ram_rd_pipe #(
      .DATAWIDTH (DATAWIDTH),
      .DEPTH     (c_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_rd),
      .in_data   (w_rd_data),
      .in_err    (w_rd_err),
      .out_valid (w_pipe_vld),
      .out_data  (w_pipe_data),
      .out_err   (w_pipe_err)
   );

   assign bus.rsp_valid = w_pipe_vld;
   assign bus.rsp_rdata = w_pipe_vld ? w_pipe_data : '0;
   assign bus.rsp_err   = w_pipe_vld & w_pipe_err;

endmodule

`default_nettype wire

// File: tb/tb_ram_sp_hs.sv
// ============================================================================
//  Module      : tb_ram_sp_hs
//  Description : Directed self-checking bench for ram_sp_hs configured with
//                ADDRWIDTH=4, DATAWIDTH=32, SIZE=12, RD_LAT=2. The parity
//                steps are compiled in when PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_sp_hs;

   localparam int AW   = 4;
   localparam int DW   = 32;
   localparam int SZ   = 12;
   localparam int LAT  = 2;

   logic clk;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   logic [31:0] exp_mem [SZ];

   ram_sp_hs_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();

   ram_sp_hs #(
      .ADDRWIDTH (AW),
      .DATAWIDTH (DW),
      .SIZE      (SZ),
      .RD_LAT    (LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_be    = be;
      tick();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      if (int'(a) < SZ) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) exp_mem[a][i*8 +: 8] = d[i*8 +: 8];
         end
      end
   endtask

   // Single read: response must appear exactly in the cycle after next.
   task automatic rd_chk(input string tag, input logic [3:0] a,
                         input logic [31:0] ed, input logic ee);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = a;
      tick();
      bus.req_valid = 1'b0;
      chk({tag, " valid_early"}, {31'd0, bus.rsp_valid}, 32'd0);
      tick();
      chk({tag, " valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      chk({tag, " rdata"}, bus.rsp_rdata, ed);
      chk({tag, " err"},   {31'd0, bus.rsp_err}, {31'd0, ee});
      tick();
      chk({tag, " valid_end"}, {31'd0, bus.rsp_valid}, 32'd0);
   endtask

   // Called right after a reset edge: ready low for SZ cycles, then high.
   task automatic init_chk(input string tag);
      chk({tag, " ready0"}, {31'd0, bus.req_ready}, 32'd0);
      chk({tag, " done0"},  {31'd0, bus.init_done}, 32'd0);
      for (int i = 1; i < SZ; i++) begin
         tick();
         chk({tag, " ready_init"}, {31'd0, bus.req_ready}, 32'd0);
      end
      tick();
      chk({tag, " ready_run"}, {31'd0, bus.req_ready}, 32'd1);
      chk({tag, " done_run"},  {31'd0, bus.init_done}, 32'd1);
      for (int i = 0; i < SZ; i++) exp_mem[i] = 32'd0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
`ifdef PARITY_EN
      bus.par_inj   = 1'b0;
`endif
      for (int i = 0; i < SZ; i++) exp_mem[i] = 32'd0;

      // 1. reset values, init duration, cleared array
      tick();
      rst_n = 1'b1;
      chk("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
      init_chk("init1");
      rd_chk("clr0",  4'd0,  32'd0, 1'b0);
      rd_chk("clr11", 4'd11, 32'd0, 1'b0);

      // 2. byte-enable merge
      wr(4'd3, 32'hDEADBEEF, 4'b1111);
      wr(4'd3, 32'h11223344, 4'b0101);
      rd_chk("be_merge", 4'd3, 32'hDE22BE44, 1'b0);
      wr(4'd3, 32'hFFFFFFFF, 4'b0000);
      rd_chk("be_none", 4'd3, 32'hDE22BE44, 1'b0);

      // 3. read after write, then back-to-back reads
      wr(4'd5, 32'hCAFEF00D, 4'b1111);
      rd_chk("raw", 4'd5, 32'hCAFEF00D, 1'b0);
      for (int i = 0; i < 8; i++) wr(i[3:0], 32'hA5000000 | (i * 32'h00010101), 4'b1111);
      for (int k = 0; k < 9; k++) begin
         if (k < 8) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = k[3:0];
         end else begin
            bus.req_valid = 1'b0;
         end
         tick();
         if (k == 0) begin
            chk("burst valid_first", {31'd0, bus.rsp_valid}, 32'd0);
         end else begin
            chk("burst valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("burst rdata", bus.rsp_rdata, exp_mem[k-1]);
         end
      end
      tick();
      chk("burst valid_end", {31'd0, bus.rsp_valid}, 32'd0);

      // 4. out-of-range access
      wr(4'd14, 32'h12345678, 4'b1111);
      rd_chk("oor14", 4'd14, 32'd0, 1'b1);
      rd_chk("oor12", 4'd12, 32'd0, 1'b1);
      for (int i = 0; i < SZ; i++) rd_chk("scan", i[3:0], exp_mem[i], 1'b0);

      // 5. reset with reads in flight, then reset mid-init at ptr 7
      bus.req_valid = 1'b1;
      bus.req_addr  = 4'd0;
      tick();
      bus.req_addr  = 4'd1;
      tick();
      bus.req_valid = 1'b0;
      rst_n         = 1'b0;
      chk("inflight first", {31'd0, bus.rsp_valid}, 32'd1);
      tick();
      rst_n = 1'b1;
      chk("inflight flushed", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst2 ready",       {31'd0, bus.req_ready}, 32'd0);
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("rst2 no_stale", {31'd0, bus.rsp_valid}, 32'd0);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      init_chk("init3");
      rd_chk("reclr3", 4'd3, 32'd0, 1'b0);

`ifdef PARITY_EN
      // 6. parity error injection
      bus.par_inj = 1'b1;
      wr(4'd2, 32'h000000AB, 4'b0001);
      bus.par_inj = 1'b0;
      rd_chk("par_inj", 4'd2, 32'h000000AB, 1'b1);
      wr(4'd2, 32'h000000AB, 4'b0001);
      rd_chk("par_ok", 4'd2, 32'h000000AB, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
